// File: rtl/wishbone_master_if.sv
// wishbone_master_if
//   Groups the core-side request/response handshake and the Wishbone
//   classic bus signals of wishbone_master. Member names keep the i_/o_
//   direction prefixes as seen from the master.
//   master : modport taken by wishbone_master
//   slave  : modport for the environment (core + Wishbone slave)
//   Core side : i_REQ, i_WE, i_SIZE, i_UNSIGNED, i_ADDR, i_WDATA,
//               o_READY, o_VALID, o_ERR, o_RDATA
//   Bus side  : o_CYC, o_STB, o_WE, o_SEL, o_ADDR, o_DATA, i_DATA, i_ACK
interface wishbone_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  i_REQ;
   logic                  i_WE;
   logic [1:0]            i_SIZE;
   logic                  i_UNSIGNED;
   logic [ADDR_WIDTH-1:0] i_ADDR;
   logic [DATA_WIDTH-1:0] i_WDATA;
   logic                  o_READY;
   logic                  o_VALID;
   logic                  o_ERR;
   logic [DATA_WIDTH-1:0] o_RDATA;
   logic                  o_CYC;
   logic                  o_STB;
   logic                  o_WE;
   logic [3:0]            o_SEL;
   logic [ADDR_WIDTH-1:0] o_ADDR;
   logic [DATA_WIDTH-1:0] o_DATA;
   logic [DATA_WIDTH-1:0] i_DATA;
   logic                  i_ACK;

   modport master (
      input  i_REQ, i_WE, i_SIZE, i_UNSIGNED, i_ADDR, i_WDATA,
      output o_READY, o_VALID, o_ERR, o_RDATA,
      output o_CYC, o_STB, o_WE, o_SEL, o_ADDR, o_DATA,
      input  i_DATA, i_ACK
   );

   modport slave (
      output i_REQ, i_WE, i_SIZE, i_UNSIGNED, i_ADDR, i_WDATA,
      input  o_READY, o_VALID, o_ERR, o_RDATA,
      input  o_CYC, o_STB, o_WE, o_SEL, o_ADDR, o_DATA,
      output i_DATA, i_ACK
   );
endinterface

// File: rtl/wishbone_master.sv
// wishbone_master
//   Single-outstanding Wishbone classic master. Turns one core load/store
//   into one bus cycle: byte-lane steering and SEL generation on the way
//   out, lane selection and sign/zero extension on the way back.
//   Misaligned accesses are answered with an error and never reach the bus.
//   Ports:
//     i_CLK  - clock, rising edge
//     i_RST  - asynchronous active-low reset
//     bus    - wishbone_master_if.master (core handshake + Wishbone bus)
//   Optional feature: define WB_TIMEOUT_EN to abort a bus cycle that sees
//   no ACK for TIMEOUT_CYCLES cycles (reported as o_ERR).
module wishbone_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic               i_CLK,
   input logic               i_RST,
   wishbone_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t                state, state_nxt;
   logic                  we_q, uns_q;
   logic [1:0]            size_q, lane_q;
   logic                  accept, misaligned, timeout;
   logic [3:0]            sel_c;
   logic [DATA_WIDTH-1:0] wdata_c, rdata_c;
   logic [7:0]            lane_byte;
   logic [15:0]           lane_half;

   assign bus.o_READY = (state == IDLE);
   assign bus.o_VALID = (state == RESP);
   assign accept      = bus.i_REQ & bus.o_READY;
   // size 11 is a word, so size[1] covers both word encodings
   assign misaligned  = ((bus.i_SIZE == 2'b01) & bus.i_ADDR[0]) |
                        (bus.i_SIZE[1] & (|bus.i_ADDR[1:0]));

   // Outbound steering: replicate narrow data on every lane, SEL picks one
   always_comb begin
      sel_c   = 4'b1111;
      wdata_c = bus.i_WDATA;
      case (bus.i_SIZE)
         2'b00: begin
            sel_c   = 4'b0001 << bus.i_ADDR[1:0];
            wdata_c = {4{bus.i_WDATA[7:0]}};
         end
         2'b01: begin
            sel_c   = bus.i_ADDR[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{bus.i_WDATA[15:0]}};
         end
         default: ;
      endcase
   end

   // Inbound: pick the lane from the latched offset, then extend
   always_comb begin
      lane_byte = bus.i_DATA[{lane_q, 3'b000} +: 8];
      lane_half = lane_q[1] ? bus.i_DATA[31:16] : bus.i_DATA[15:0];
      case (size_q)
         2'b00:   rdata_c = uns_q ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
         2'b01:   rdata_c = uns_q ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
         default: rdata_c = bus.i_DATA;
      endcase
   end

`ifdef WB_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   // Held at zero outside BUS, so every bus cycle starts counting from 0
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST)              tmo_cnt <= '0;
      else if (state != BUS)   tmo_cnt <= '0;
      else if (!bus.i_ACK)     tmo_cnt <= tmo_cnt + 8'd1;
   end

   // Fires on the edge that ends the TIMEOUT_CYCLES-th ACK-less BUS cycle
   assign timeout = (state == BUS) && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = misaligned ? RESP : BUS;
         BUS:     if (bus.i_ACK || timeout) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         size_q      <= 2'b00;
         lane_q      <= 2'b00;
         bus.o_ERR   <= 1'b0;
         bus.o_RDATA <= '0;
         bus.o_CYC   <= 1'b0;
         bus.o_STB   <= 1'b0;
         bus.o_WE    <= 1'b0;
         bus.o_SEL   <= 4'b0000;
         bus.o_ADDR  <= '0;
         bus.o_DATA  <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               we_q        <= bus.i_WE;
               uns_q       <= bus.i_UNSIGNED;
               size_q      <= bus.i_SIZE;
               lane_q      <= bus.i_ADDR[1:0];
               bus.o_RDATA <= '0;
               bus.o_ERR   <= misaligned;
               if (!misaligned) begin
                  bus.o_CYC  <= 1'b1;
                  bus.o_STB  <= 1'b1;
                  bus.o_WE   <= bus.i_WE;
                  bus.o_SEL  <= sel_c;
                  bus.o_ADDR <= {bus.i_ADDR[ADDR_WIDTH-1:2], 2'b00};
                  bus.o_DATA <= bus.i_WE ? wdata_c : '0;
               end
            end
            BUS: if (bus.i_ACK || timeout) begin
               // ACK takes priority over a simultaneous timeout
               bus.o_CYC   <= 1'b0;
               bus.o_STB   <= 1'b0;
               bus.o_WE    <= 1'b0;
               bus.o_SEL   <= 4'b0000;
               bus.o_DATA  <= '0;
               bus.o_ERR   <= !bus.i_ACK;
               bus.o_RDATA <= (bus.i_ACK && !we_q) ? rdata_c : '0;
            end
            RESP: bus.o_ERR <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_wishbone_master.sv
module tb_wishbone_master;
`ifdef WB_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 255;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   wishbone_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   wishbone_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
      .i_CLK (clk),
      .i_RST (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // One transaction: drive, act as slave (ACK after ack_after CYC cycles),
   // check bus phase on the first CYC cycle and the response via scoreboard.
   task automatic txn(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] slv_data, input int ack_after, input logic hold_req,
                      input logic [31:0] e_addr, input logic [3:0] e_sel,
                      input logic [31:0] e_data, input logic e_err,
                      input logic [31:0] e_rdata, input int e_cyc);
      exp_t e;
      int   n   = 0;
      int   cyc = 0;
      bit   got = 0;
      @(negedge clk);
      bus.i_REQ      = 1'b1;
      bus.i_WE       = we;
      bus.i_SIZE     = size;
      bus.i_UNSIGNED = uns;
      bus.i_ADDR     = addr;
      bus.i_WDATA    = wdata;
      sb.push_back('{e_err, e_rdata});
      @(posedge clk);
      while (!got && n < 400) begin
         @(negedge clk);
         n++;
         if (!hold_req) bus.i_REQ = 1'b0;
         if (bus.o_VALID) begin
            got       = 1;
            bus.i_ACK = 1'b0;
            bus.i_REQ = 1'b0;
            if (sb.size() == 0) chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            else begin
               e = sb.pop_front();
               chk({tag, ".err"}, {31'b0, bus.o_ERR}, {31'b0, e.err});
               chk({tag, ".rdata"}, bus.o_RDATA, e.rdata);
            end
            chk({tag, ".cyc_cnt"}, cyc, e_cyc);
            chk({tag, ".latency"}, n, e_cyc + 1);
            chk({tag, ".cyc_off"}, {31'b0, bus.o_CYC}, 32'd0);
         end else begin
            if (bus.o_CYC) begin
               cyc++;
               if (cyc == 1) begin
                  chk({tag, ".addr"}, bus.o_ADDR, e_addr);
                  chk({tag, ".sel"}, {28'b0, bus.o_SEL}, {28'b0, e_sel});
                  chk({tag, ".data"}, bus.o_DATA, e_data);
                  chk({tag, ".we"}, {31'b0, bus.o_WE}, {31'b0, we});
                  chk({tag, ".stb"}, {31'b0, bus.o_STB}, 32'd1);
                  chk({tag, ".busy"}, {31'b0, bus.o_READY}, 32'd0);
               end
            end
            bus.i_ACK  = bus.o_CYC && (cyc == ack_after + 1);
            bus.i_DATA = bus.i_ACK ? slv_data : $urandom;
         end
      end
      if (!got) chk({tag, ".no_valid"}, 32'd0, 32'd1);
      @(negedge clk);
      chk({tag, ".valid_pulse"}, {31'b0, bus.o_VALID}, 32'd0);
      chk({tag, ".ready_after"}, {31'b0, bus.o_READY}, 32'd1);
      chk({tag, ".no_reissue"}, {31'b0, bus.o_CYC}, 32'd0);
   endtask

   initial begin
      int vcnt;
      int ccnt;
      int unstable;
      bus.i_REQ = 0; bus.i_WE = 0; bus.i_SIZE = 0; bus.i_UNSIGNED = 0;
      bus.i_ADDR = 0; bus.i_WDATA = 0; bus.i_DATA = 0; bus.i_ACK = 0;
      repeat (2) @(negedge clk);
      chk("rst.ready", {31'b0, bus.o_READY}, 32'd1);
      chk("rst.ctl", {26'b0, bus.o_VALID, bus.o_ERR, bus.o_CYC, bus.o_STB, bus.o_WE, 1'b0}, 32'd0);
      chk("rst.sel", {28'b0, bus.o_SEL}, 32'd0);
      chk("rst.addr", bus.o_ADDR, 32'd0);
      chk("rst.data", bus.o_DATA, 32'd0);
      chk("rst.rdata", bus.o_RDATA, 32'd0);
      rst_n = 1'b1;

      //   tag       we size uns addr   wdata         slave data  ack hold e_addr e_sel e_data     err e_rdata    cyc
      txn("st_w",   1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,       1, 0, 32'h10, 4'hF, 32'hDEADBEEF, 0, 32'h0,        2);
      txn("st_b",   1, 2'b00, 0, 32'h13, 32'h123456A5, 32'h0,       1, 0, 32'h10, 4'h8, 32'hA5A5A5A5, 0, 32'h0,        2);
      txn("ld_bs",  0, 2'b00, 0, 32'h13, 32'hCAFEF00D, 32'hA5000000, 1, 0, 32'h10, 4'h8, 32'h0,       0, 32'hFFFFFFA5, 2);
      txn("ld_bu",  0, 2'b00, 1, 32'h13, 32'hCAFEF00D, 32'hA5000000, 1, 0, 32'h10, 4'h8, 32'h0,       0, 32'h000000A5, 2);
      txn("ld_hu",  0, 2'b01, 1, 32'h12, 32'h0,        32'h80011234, 1, 0, 32'h10, 4'hC, 32'h0,       0, 32'h00008001, 2);
      txn("ld_hs",  0, 2'b01, 0, 32'h12, 32'h0,        32'h80011234, 1, 0, 32'h10, 4'hC, 32'h0,       0, 32'hFFFF8001, 2);
      txn("mis_w",  0, 2'b10, 0, 32'h06, 32'h0,        32'h11111111, 1, 0, 32'h0,  4'h0, 32'h0,       1, 32'h0,        0);
      txn("mis_h",  1, 2'b01, 0, 32'h03, 32'h5555,     32'h0,       1, 0, 32'h0,  4'h0, 32'h0,       1, 32'h0,        0);
      txn("st_h",   1, 2'b01, 0, 32'h02, 32'hFFFF1234, 32'h0,       3, 0, 32'h0,  4'hC, 32'h12341234, 0, 32'h0,        4);
      txn("ld_b1",  0, 2'b00, 0, 32'h21, 32'h0,        32'h00007F00, 1, 0, 32'h20, 4'h2, 32'h0,       0, 32'h0000007F, 2);
      txn("ld_hs0", 0, 2'b01, 0, 32'h30, 32'h0,        32'h1234F00F, 1, 0, 32'h30, 4'h3, 32'h0,       0, 32'hFFFFF00F, 2);
      txn("ld_s3",  0, 2'b11, 0, 32'h24, 32'h0,        32'h80000000, 1, 1, 32'h24, 4'hF, 32'h0,       0, 32'h80000000, 2);

      // Reset in the middle of a bus cycle
      @(negedge clk);
      bus.i_REQ = 1; bus.i_WE = 0; bus.i_SIZE = 2'b10; bus.i_ADDR = 32'h40;
      @(posedge clk);
      @(negedge clk);
      bus.i_REQ = 0;
      chk("rstbus.cyc_before", {31'b0, bus.o_CYC}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstbus.cyc_async", {31'b0, bus.o_CYC}, 32'd0);
      chk("rstbus.stb_async", {31'b0, bus.o_STB}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      vcnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.o_VALID) vcnt++;
      end
      chk("rstbus.no_valid", vcnt, 0);
      chk("rstbus.ready", {31'b0, bus.o_READY}, 32'd1);

`ifdef WB_TIMEOUT_EN
      txn("tmo", 0, 2'b10, 0, 32'h50, 32'h0, 32'h12345678, 1000, 0, 32'h50, 4'hF, 32'h0, 1, 32'h0, 4);
`else
      // Slave never answers: the cycle must stay open
      @(negedge clk);
      bus.i_REQ = 1; bus.i_WE = 1; bus.i_SIZE = 2'b00; bus.i_ADDR = 32'h51; bus.i_WDATA = 32'h3C;
      @(posedge clk);
      vcnt = 0; ccnt = 0; unstable = 0;
      repeat (300) begin
         @(negedge clk);
         bus.i_REQ = 0;
         if (bus.o_CYC) ccnt++;
         if (bus.o_VALID) vcnt++;
         if (bus.o_SEL !== 4'h2 || bus.o_ADDR !== 32'h50 || bus.o_DATA !== 32'h3C3C3C3C) unstable++;
      end
      chk("noto.cyc_cycles", ccnt, 300);
      chk("noto.valid", vcnt, 0);
      chk("noto.stable", unstable, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`endif
      txn("after", 0, 2'b10, 1, 32'h60, 32'h0, 32'h0BADF00D, 1, 0, 32'h60, 4'hF, 32'h0, 0, 32'h0BADF00D, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
